// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, md_cnt width,
// and the bundle of pipeline-register controls.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  localparam int MD_CNT_W = 4;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctrl_t;

  // Freeze fetch and squash both front registers while the core is held in reset.
  localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_JUMP = '{pc_write: 1'b1, ifid_write: 1'b1,
                                       ifid_flush: 1'b1, idex_bubble: 1'b0};

  // $zero is hardwired, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rw,
    input logic [4:0] rs,
    input logic       use_rs,
    input logic [4:0] rt,
    input logic       use_rt
  );
    return mem_read && (ex_rw != 5'd0) &&
           ((use_rs && (rs == ex_rw)) || (use_rt && (rt == ex_rw)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources in, PC / IF/ID / ID/EX controls
// and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_jump;
  logic             id_md_start;
  logic [4:0]       ex_rw;
  logic             ex_mem_read;
  logic             ex_branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           ex_rw, ex_mem_read, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           ex_rw, ex_mem_read, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Stall-cycle and flush performance counters; compiled only when
// HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 1'b1;
      if (flush) flush_count  <= flush_count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / jump / mult-div hazard sequencer for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state   | meaning
// RUN     | normal issue; branch > load-use > mult/div issue > jump priority
// MD_WAIT | mult/div occupying HI/LO; front end held, md_cnt counts down to 1
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  generate
    if (MD_LATENCY < 2 || MD_LATENCY > 16) begin : g_bad_latency
      $error("pipeline_hazard_ctrl: MD_LATENCY must be within 2..16");
    end
  endgenerate

  hz_state_e           state;
  hz_state_e           state_next;
  logic [MD_CNT_W-1:0] md_cnt;
  logic [MD_CNT_W-1:0] md_cnt_next;
  pipe_ctrl_t          ctrl;
  logic                md_busy;
  logic                lu_hit;

  assign lu_hit = load_use_hit(hz.ex_mem_read, hz.ex_rw,
                               hz.id_rs, hz.id_use_rs,
                               hz.id_rt, hz.id_use_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    ctrl        = CTRL_NORMAL;
    md_busy     = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ctrl = CTRL_SQUASH;
        end else if (lu_hit) begin
          // A pending mult/div in ID is simply re-presented next cycle.
          ctrl = CTRL_STALL;
        end else if (hz.id_md_start) begin
          ctrl        = CTRL_NORMAL;
          state_next  = MD_WAIT;
          md_cnt_next = MD_LOAD;
        end else if (hz.id_jump) begin
          ctrl = CTRL_JUMP;
        end
      end

      MD_WAIT: begin
        ctrl    = CTRL_STALL;
        md_busy = 1'b1;
        if (md_cnt == MD_CNT_W'(1)) begin
          state_next = RUN;
        end else begin
          md_cnt_next = md_cnt - 1'b1;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    if (reset) begin
      ctrl    = CTRL_RESET;
      md_busy = 1'b0;
    end
  end

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.ifid_write  = ctrl.ifid_write;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.md_busy     = md_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk          (clk),
    .reset        (reset),
    .stall        (~ctrl.pc_write),
    .flush        (ctrl.ifid_flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_count  = flush_count;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, squashes, mult/div occupancy,
// reset recovery and (when HAZARD_PERF_CNT_EN is defined) the counters.
module tb_pipeline_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CW     = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(
    .MD_LATENCY (MD_LAT),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
    hz.id_jump = 1'b0; hz.id_md_start = 1'b0;
    hz.ex_rw = 5'd0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
  endtask

  // Advance to just after the next rising edge; caller then drives and checks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_counters(input string tag);
    logic [CW-1:0] es, ef;
    es = PERF ? exp_stall : '0;
    ef = PERF ? exp_flush : '0;
    checks++;
    if (hz.stall_cycles !== es) begin
      failures++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, hz.stall_cycles, es);
    end
    checks++;
    if (hz.flush_count !== ef) begin
      failures++;
      $display("FAIL %s flush_count got=%0d exp=%0d", tag, hz.flush_count, ef);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    cyc(); cyc(); settle();
    checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%b exp=0", hz.pc_write); end
    checks++; if (hz.ifid_write !== 1'b0) begin failures++; $display("FAIL rst_ifid_write got=%b exp=0", hz.ifid_write); end
    checks++; if (hz.ifid_flush !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%b exp=1", hz.ifid_flush); end
    checks++; if (hz.idex_bubble !== 1'b1) begin failures++; $display("FAIL rst_idex_bubble got=%b exp=1", hz.idex_bubble); end
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL rst_md_busy got=%b exp=0", hz.md_busy); end
    check_counters("rst");
    cyc(); reset = 1'b0; settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL run_pc_write got=%b exp=1", hz.pc_write); end
    checks++; if (hz.ifid_write !== 1'b1) begin failures++; $display("FAIL run_ifid_write got=%b exp=1", hz.ifid_write); end
    checks++; if (hz.ifid_flush !== 1'b0) begin failures++; $display("FAIL run_ifid_flush got=%b exp=0", hz.ifid_flush); end
    checks++; if (hz.idex_bubble !== 1'b0) begin failures++; $display("FAIL run_idex_bubble got=%b exp=0", hz.idex_bubble); end
  endtask

  task automatic test_load_use();
    cyc(); idle();
    hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    settle();
    checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL lu_rs_pc_write got=%b exp=0", hz.pc_write); end
    checks++; if (hz.ifid_write !== 1'b0) begin failures++; $display("FAIL lu_rs_ifid_write got=%b exp=0", hz.ifid_write); end
    checks++; if (hz.idex_bubble !== 1'b1) begin failures++; $display("FAIL lu_rs_idex_bubble got=%b exp=1", hz.idex_bubble); end
    checks++; if (hz.ifid_flush !== 1'b0) begin failures++; $display("FAIL lu_rs_ifid_flush got=%b exp=0", hz.ifid_flush); end
    exp_stall++;
    // EX now holds the bubble; same instruction in ID proceeds.
    cyc(); hz.ex_mem_read = 1'b0; hz.ex_rw = 5'd0; settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL lu_after_pc_write got=%b exp=1", hz.pc_write); end
    checks++; if (hz.idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_after_idex_bubble got=%b exp=0", hz.idex_bubble); end
    cyc(); idle();
    hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd0; hz.id_rs = 5'd0; hz.id_use_rs = 1'b1; hz.id_rt = 5'd0; hz.id_use_rt = 1'b1;
    settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL lu_r0_pc_write got=%b exp=1", hz.pc_write); end
    cyc(); idle();
    hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd5; hz.id_rt = 5'd5; hz.id_use_rt = 1'b1; hz.id_rs = 5'd9; hz.id_use_rs = 1'b1;
    settle();
    checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL lu_rt_pc_write got=%b exp=0", hz.pc_write); end
    exp_stall++;
    cyc(); idle();
    hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd5; hz.id_rt = 5'd5; hz.id_use_rt = 1'b0;
    settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL lu_unused_rt_pc_write got=%b exp=1", hz.pc_write); end
    cyc(); idle();
    hz.ex_mem_read = 1'b0; hz.ex_rw = 5'd7; hz.id_rs = 5'd7; hz.id_use_rs = 1'b1;
    settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL lu_noload_pc_write got=%b exp=1", hz.pc_write); end
    cyc(); idle(); settle();
    check_counters("lu");
  endtask

  task automatic test_branch();
    cyc(); idle();
    hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    hz.ex_branch_taken = 1'b1; hz.id_md_start = 1'b1;
    settle();
    checks++; if (hz.ifid_flush !== 1'b1) begin failures++; $display("FAIL br_ifid_flush got=%b exp=1", hz.ifid_flush); end
    checks++; if (hz.idex_bubble !== 1'b1) begin failures++; $display("FAIL br_idex_bubble got=%b exp=1", hz.idex_bubble); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL br_pc_write got=%b exp=1", hz.pc_write); end
    checks++; if (hz.ifid_write !== 1'b1) begin failures++; $display("FAIL br_ifid_write got=%b exp=1", hz.ifid_write); end
    exp_flush++;
    // The ignored md_start must not have entered MD_WAIT.
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL br_md_busy got=%b exp=0", hz.md_busy); end
    check_counters("br");
  endtask

  task automatic test_jump();
    cyc(); idle(); hz.id_jump = 1'b1; settle();
    checks++; if (hz.ifid_flush !== 1'b1) begin failures++; $display("FAIL j_ifid_flush got=%b exp=1", hz.ifid_flush); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL j_pc_write got=%b exp=1", hz.pc_write); end
    checks++; if (hz.idex_bubble !== 1'b0) begin failures++; $display("FAIL j_idex_bubble got=%b exp=0", hz.idex_bubble); end
    exp_flush++;
    cyc(); hz.ex_branch_taken = 1'b1; settle();
    checks++; if (hz.idex_bubble !== 1'b1) begin failures++; $display("FAIL jbr_idex_bubble got=%b exp=1", hz.idex_bubble); end
    checks++; if (hz.ifid_flush !== 1'b1) begin failures++; $display("FAIL jbr_ifid_flush got=%b exp=1", hz.ifid_flush); end
    exp_flush++;
    cyc(); idle(); settle();
    checks++; if (hz.ifid_flush !== 1'b0) begin failures++; $display("FAIL j_after_ifid_flush got=%b exp=0", hz.ifid_flush); end
    check_counters("jump");
  endtask

  task automatic test_md();
    cyc(); idle(); hz.id_md_start = 1'b1; settle();
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL md_issue_pc_write got=%b exp=1", hz.pc_write); end
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL md_issue_md_busy got=%b exp=0", hz.md_busy); end
    for (int i = 1; i < MD_LAT; i++) begin
      cyc(); idle();
      hz.ex_branch_taken = (i == 1); hz.id_jump = (i == 2);
      settle();
      checks++; if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL md_wait%0d_md_busy got=%b exp=1", i, hz.md_busy); end
      checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL md_wait%0d_pc_write got=%b exp=0", i, hz.pc_write); end
      checks++; if (hz.ifid_flush !== 1'b0) begin failures++; $display("FAIL md_wait%0d_ifid_flush got=%b exp=0", i, hz.ifid_flush); end
      checks++; if (hz.idex_bubble !== 1'b1) begin failures++; $display("FAIL md_wait%0d_idex_bubble got=%b exp=1", i, hz.idex_bubble); end
      exp_stall++;
    end
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL md_done_md_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL md_done_pc_write got=%b exp=1", hz.pc_write); end
    check_counters("md");
  endtask

  task automatic test_back_to_back();
    cyc(); idle(); hz.id_md_start = 1'b1; settle();
    for (int i = 1; i < MD_LAT; i++) begin
      cyc(); idle(); settle();
      exp_stall++;
    end
    cyc(); idle(); hz.id_md_start = 1'b1; settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL b2b_issue_md_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL b2b_issue_pc_write got=%b exp=1", hz.pc_write); end
    for (int i = 1; i < MD_LAT; i++) begin
      cyc(); idle(); settle();
      checks++; if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL b2b_wait%0d_md_busy got=%b exp=1", i, hz.md_busy); end
      exp_stall++;
    end
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL b2b_done_md_busy got=%b exp=0", hz.md_busy); end
    check_counters("b2b");
  endtask

  task automatic test_md_vs_load_use();
    cyc(); idle();
    hz.id_md_start = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rw = 5'd3; hz.id_rs = 5'd3; hz.id_use_rs = 1'b1;
    settle();
    checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL mdlu_pc_write got=%b exp=0", hz.pc_write); end
    exp_stall++;
    cyc(); hz.ex_mem_read = 1'b0; hz.ex_rw = 5'd0; settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL mdlu_reissue_md_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL mdlu_reissue_pc_write got=%b exp=1", hz.pc_write); end
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL mdlu_wait_md_busy got=%b exp=1", hz.md_busy); end
    exp_stall++;
    for (int i = 2; i < MD_LAT; i++) begin
      cyc(); idle(); settle();
      exp_stall++;
    end
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL mdlu_done_md_busy got=%b exp=0", hz.md_busy); end
    check_counters("mdlu");
  endtask

  task automatic test_reset_mid_md();
    cyc(); idle(); hz.id_md_start = 1'b1; settle();
    cyc(); idle(); settle();
    checks++; if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL rmd_wait1_md_busy got=%b exp=1", hz.md_busy); end
    cyc(); reset = 1'b1; settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL rmd_in_rst_md_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.ifid_flush !== 1'b1) begin failures++; $display("FAIL rmd_in_rst_ifid_flush got=%b exp=1", hz.ifid_flush); end
    checks++; if (hz.pc_write !== 1'b0) begin failures++; $display("FAIL rmd_in_rst_pc_write got=%b exp=0", hz.pc_write); end
    cyc(); reset = 1'b0; settle();
    exp_stall = '0; exp_flush = '0;
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL rmd_after_md_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.pc_write !== 1'b1) begin failures++; $display("FAIL rmd_after_pc_write got=%b exp=1", hz.pc_write); end
    check_counters("rmd");
    cyc(); settle();
    checks++; if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL rmd_after2_md_busy got=%b exp=0", hz.md_busy); end
    check_counters("rmd2");
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_md();
    test_back_to_back();
    test_md_vs_load_use();
    test_reset_mid_md();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sequences the stages that the forwarding unit cannot resolve: load-use stalls, taken-branch and jump squashes, and multi-cycle multiply/divide occupancy. It sits in ID, beside the forwarding unit, and drives the PC, IF/ID and ID/EX pipeline-register controls.

## Interface
- MD_LATENCY, 4: cycles from mult/div issue to HI/LO valid; legal range 2..16.
- CNT_W, 32: width of the performance counters.
- CLK  in  1  core clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1 each  instruction in ID actually reads Rs / Rt.
- ID_Jump  in  1  J/JAL/JR decoded in ID.
- ID_MdStart  in  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- EX_Rw  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- PCWrite  out  1  PC may update.
- IFID_Write  out  1  IF/ID register may load.
- IFID_Flush  out  1  clear IF/ID to a NOP.
- IDEX_Bubble  out  1  zero the ID/EX control fields.
- MD_Busy  out  1  multiply/divide unit is occupied.
- StallCycles, FlushCount  out  CNT_W each  performance counters.

## Operation
- State machine with two states: RUN and MD_WAIT. A down-counter `md_cnt` (4 bits) runs alongside it.
- Events are evaluated in RUN, highest priority first:
  1. Branch: EX_BranchTaken. Outputs PCWrite=1, IFID_Flush=1, IDEX_Bubble=1, IFID_Write=1. ID_MdStart and the load-use check are ignored.
  2. Load-use: EX_MemRead & EX_Rw!=0 & ((ID_UseRs & ID_Rs==EX_Rw) | (ID_UseRt & ID_Rt==EX_Rw)). Outputs PCWrite=0, IFID_Write=0, IDEX_Bubble=1. The stall lasts exactly one cycle; the forwarding unit covers the following cycle. ID_MdStart is ignored this cycle; the instruction re-presents it next cycle.
  3. Mult/div issue: ID_MdStart. The instruction advances normally. Next state is MD_WAIT, with md_cnt loaded to MD_LATENCY-1.
  4. Jump: ID_Jump. Outputs IFID_Flush=1, PCWrite=1. ID_MdStart and ID_Jump are mutually exclusive by decode.
  5. None of the above: PCWrite=1, IFID_Write=1, all other outputs 0.
- MD_WAIT:
  - Outputs PCWrite=0, IFID_Write=0, IDEX_Bubble=1, MD_Busy=1.
  - If md_cnt==1, next state is RUN; otherwise md_cnt decrements.
  - EX_BranchTaken and ID_Jump are ignored (EX holds only the mult or bubbles).
- MD_Busy=0 in RUN.
- Register 0 never triggers a load-use stall.
- Reset at any time, including mid-MD_WAIT: next state RUN, md_cnt=0, counters cleared.

## Timing
- While Reset is high, outputs are forced to PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, MD_Busy=0, StallCycles=0, FlushCount=0.
- All pipeline-control outputs are combinational from the state and the current inputs, so they act in the same cycle the hazard is detected.
- Mult/div issue:
  - Issue in cycle T.
  - MD_WAIT, with MD_Busy=1, in cycles T+1 .. T+MD_LATENCY-1, giving MD_LATENCY-1 stall cycles.
  - RUN resumes at T+MD_LATENCY.
- Back-to-back: an ID_MdStart in the first RUN cycle after MD_WAIT re-enters MD_WAIT normally.

## Configuration
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - StallCycles increments on every cycle with PCWrite=0 outside Reset.
  - FlushCount increments on every cycle with IFID_Flush=1 outside Reset.
  - Both wrap modulo 2^CNT_W.
- Undefined: no counter registers; StallCycles and FlushCount are tied to 0.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum {RUN, MD_WAIT};
  - an MD_CNT_W=4 constant;
  - a `pipe_ctrl_t` struct bundling PCWrite, IFID_Write, IFID_Flush and IDEX_Bubble.
- One sub-module, `hazard_perf_cnt`, contains the two counters and is instantiated only under HAZARD_PERF_CNT_EN.
- The FSM, md_cnt and the priority logic stay in the top module.

## Test plan
- Load-use: EX_MemRead=1, EX_Rw=8, ID_Rs=8, ID_UseRs=1 → one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1. The next cycle (EX bubble) is normal. With EX_Rw=0, no stall.
- Branch overriding load-use: EX_BranchTaken=1 in the same cycle as a load-use match → IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, FlushCount+1.
- Mult/div with MD_LATENCY=4: ID_MdStart at T → MD_Busy=1 and PCWrite=0 for exactly 3 cycles, then RUN. StallCycles increases by 3.
- Reset mid-MD_WAIT: assert Reset in the 2nd MD_WAIT cycle → next cycle is RUN, MD_Busy=0, counters 0. During Reset, IFID_Flush=1 and PCWrite=0.
- Jump: ID_Jump=1 → IFID_Flush=1, PCWrite=1, IDEX_Bubble=0 for one cycle. A simultaneous EX_BranchTaken also sets IDEX_Bubble=1.
- Macro off: build without HAZARD_PERF_CNT_EN → StallCycles and FlushCount stay 0 through all of the above.
